// File: rtl/grf_wport_arb_if.sv
// grf_wport_arb_if
//   Bundles the handshake and data buses around the register-file write-port
//   arbiter: WB stage write, long-unit result return, long-op issue, decode
//   read addresses, and the arbitrated register-file write port.
//   master : the surrounding pipeline / bench (drives WB, LU, issue, decode)
//   slave  : the arbiter (drives lu_ready, dec_stall, wb_hold, grf_*)
interface grf_wport_arb_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [31:0] lu_pc;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        dec_stall;
  logic        wb_hold;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  modport master (
    output wb_we, wb_addr, wb_data, wb_pc,
    output lu_valid, lu_addr, lu_data, lu_pc,
    output issue_valid, issue_addr, rd_a1, rd_a2,
    input  lu_ready, dec_stall, wb_hold, grf_wa, grf_wd, grf_pc
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, wb_pc,
    input  lu_valid, lu_addr, lu_data, lu_pc,
    input  issue_valid, issue_addr, rd_a1, rd_a2,
    output lu_ready, dec_stall, wb_hold, grf_wa, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wport_arb.sv
// grf_wport_arb
//   Shares the register file's single write port between the WB stage and an
//   out-of-order long-latency unit. Long-unit results wait in a small FIFO and
//   drain on cycles WB does not write; a starvation guard holds WB for one
//   cycle to force a drain. A pending-destination scoreboard drives the
//   decode stall for RAW/WAW hazards against outstanding long ops.
// Ports
//   clk   : clock
//   reset : asynchronous active-high reset (empties FIFO, clears scoreboard)
//   bus   : grf_wport_arb_if.slave (WB, long unit, issue, decode, grf write)
module grf_wport_arb #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  grf_wport_arb_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [GW-1:0] AGE_LIMIT = GW'(STARVE_LIMIT);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] age_q, age_d;
  logic          wb_hold_q, wb_hold_d;
  logic [31:0]   pending_q, pending_d;

  logic          empty_s, full_s, wb_sel_s, pop_s, push_s, lu_ready_s, dec_stall_s;
  logic [4:0]    grf_wa_s;
  logic [31:0]   grf_wd_s, grf_pc_s;

  // Write-port selection and FIFO handshake, from registered state and inputs
  always_comb begin
    empty_s  = (count_q == CW'(0));
    full_s   = (count_q == FULL_CNT);
    wb_sel_s = bus.wb_we && (bus.wb_addr != 5'd0);
    // A held WB always yields to the FIFO head; otherwise the head drains only
    // when WB is not writing a real register.
    pop_s    = !empty_s && (wb_hold_q || !wb_sel_s);
    // The forced pop is known from registered state alone, so a full FIFO can
    // still accept during it without a path from the WB inputs.
    lu_ready_s = !full_s || wb_hold_q;
    // Results for register 0 are acknowledged but never stored.
    push_s   = bus.lu_valid && lu_ready_s && (bus.lu_addr != 5'd0);
    grf_wa_s = 5'd0;
    grf_wd_s = 32'd0;
    grf_pc_s = 32'd0;
    if (pop_s) begin
      grf_wa_s = fifo_addr_q[rd_ptr_q];
      grf_wd_s = fifo_data_q[rd_ptr_q];
      grf_pc_s = fifo_pc_q[rd_ptr_q];
    end else if (wb_sel_s && !wb_hold_q) begin
      grf_wa_s = bus.wb_addr;
      grf_wd_s = bus.wb_data;
      grf_pc_s = bus.wb_pc;
    end else begin
      grf_wa_s = 5'd0;
      grf_wd_s = 32'd0;
      grf_pc_s = 32'd0;
    end
  end

  // Next-state for pointers, occupancy, starvation age and scoreboard
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_s || empty_s) begin
      age_d = GW'(0);
    end else begin
      age_d = age_q + GW'(1);
    end
    // Registering the comparison gives a one-cycle hold whose pop clears age.
    wb_hold_d = (age_d == AGE_LIMIT);
    pending_d = pending_q;
    if (pop_s) begin
      pending_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    // Applied after the clear so a same-register issue keeps the bit set.
    if (bus.issue_valid && (bus.issue_addr != 5'd0)) begin
      pending_d[bus.issue_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Decode stall against outstanding long-op destinations (reg 0 never stalls)
  always_comb begin
    dec_stall_s = ((bus.rd_a1 != 5'd0) && pending_q[bus.rd_a1]) ||
                  ((bus.rd_a2 != 5'd0) && pending_q[bus.rd_a2]) ||
                  (bus.issue_valid && (bus.issue_addr != 5'd0) && pending_q[bus.issue_addr]);
  end

  // State registers; reset discards buffered results and pending bits at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= AW'(0);
      wr_ptr_q  <= AW'(0);
      count_q   <= CW'(0);
      age_q     <= GW'(0);
      wb_hold_q <= 1'b0;
      pending_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= 5'd0;
        fifo_data_q[i] <= 32'd0;
        fifo_pc_q[i]   <= 32'd0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      wb_hold_q <= wb_hold_d;
      pending_q <= pending_d;
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= bus.lu_addr;
        fifo_data_q[wr_ptr_q] <= bus.lu_data;
        fifo_pc_q[wr_ptr_q]   <= bus.lu_pc;
      end
    end
  end

  assign bus.lu_ready  = lu_ready_s;
  assign bus.dec_stall = dec_stall_s;
  assign bus.wb_hold   = wb_hold_q;
  assign bus.grf_wa    = grf_wa_s;
  assign bus.grf_wd    = grf_wd_s;
  assign bus.grf_pc    = grf_pc_s;
endmodule
